tx_fifo_ctrlmod: RTL and testbench

Byte-buffering transmit controller placed directly upstream of the UART transmit function module (tx_funcmod). Accepts bytes from the application through a single-cycle write strobe into a power-of-two FIFO. Drains the FIFO one byte per frame by driving tx_funcmod's iCall/iData and consuming its one-cycle oDone pulse. Optionally inserts an idle gap between frames.

---
 rtl/tx_fifo_ctrlmod.sv | 167 ++++++++++++++++
 tb/tb_tx_fifo_ctrlmod.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_ctrlmod.sv
// tx_fifo_ctrlmod: byte FIFO feeding tx_funcmod, one byte per frame.
// Optional inter-frame gap compiled in with macro TX_FIFO_CTRL_GAP_EN.
//
// Ports:
//   CLOCK, RESET          clock, async active-low reset
//   iWrite, iWData        application write strobe and byte
//   oFull, oEmpty, oCount FIFO status from the registered occupancy
//   oOverflow             sticky, set by a write while full
//   oCall, oData          to tx_funcmod iCall/iData, registered together
//   iDone                 from tx_funcmod oDone, end-of-frame pulse
//   oBusy                 FSM not in IDLE
//   oSent                 one-cycle pulse per completed frame
module tx_fifo_ctrlmod #(
    parameter int unsigned AW         = 4,
    parameter int unsigned GAP_CYCLES = 434
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iWrite,
    input  logic [7:0]    iWData,
    output logic          oFull,
    output logic          oEmpty,
    output logic [AW:0]   oCount,
    output logic          oOverflow,
    output logic          oCall,
    output logic [7:0]    oData,
    input  logic          iDone,
    output logic          oBusy,
    output logic          oSent
);

    localparam int unsigned DEPTH = 2 ** AW;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : gBadGap
        $error("GAP_CYCLES must be within 1..65535");
    end

`ifdef TX_FIFO_CTRL_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        CALL,
        GAP
    } state_t;

    localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
`else
    typedef enum logic [1:0] {
        IDLE,
        CALL
    } state_t;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wPtr;
    logic [AW-1:0] rPtr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          callNxt;
    logic          sentNxt;
    state_t        state;
    state_t        stateNxt;

    assign oCount = count;
    assign oFull  = (count == (AW+1)'(DEPTH));
    assign oEmpty = (count == '0);
    assign oBusy  = (state != IDLE);

    // Acceptance looks only at the registered full flag, so a pop on
    // the same edge never makes room for a write.
    assign push = iWrite & ~oFull;

`ifdef TX_FIFO_CTRL_GAP_EN
    logic [15:0] gapCnt;

    // Counter sits at zero outside GAP, so it is cleared on entry.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            gapCnt <= '0;
        end else if (state == GAP) begin
            gapCnt <= gapCnt + 16'd1;
        end else begin
            gapCnt <= '0;
        end
    end
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        callNxt  = oCall;
        sentNxt  = 1'b0;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!oEmpty) begin
                    pop      = 1'b1;
                    callNxt  = 1'b1;
                    stateNxt = CALL;
                end
            end
            CALL: begin
                if (iDone) begin
                    callNxt  = 1'b0;
                    sentNxt  = 1'b1;
`ifdef TX_FIFO_CTRL_GAP_EN
                    stateNxt = GAP;
`else
                    stateNxt = IDLE;
`endif
                end
            end
`ifdef TX_FIFO_CTRL_GAP_EN
            GAP: begin
                if (gapCnt == GapLast) begin
                    stateNxt = IDLE;
                end
            end
`endif
            default: begin
                callNxt  = 1'b0;
                stateNxt = IDLE;
            end
        endcase
    end

    // Storage carries no reset; contents are discarded via the pointers.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wPtr] <= iWData;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wPtr      <= '0;
            rPtr      <= '0;
            count     <= '0;
            oOverflow <= 1'b0;
            oCall     <= 1'b0;
            oData     <= 8'h00;
            oSent     <= 1'b0;
        end else begin
            if (push) begin
                wPtr <= wPtr + 1'b1;
            end
            if (pop) begin
                rPtr  <= rPtr + 1'b1;
                oData <= mem[rPtr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (iWrite && oFull) begin
                oOverflow <= 1'b1;
            end
            oCall <= callNxt;
            oSent <= sentNxt;
        end
    end

endmodule

// File: tb/tb_tx_fifo_ctrlmod.sv
// tb_tx_fifo_ctrlmod: randomized bench for tx_fifo_ctrlmod.
// Queue-based reference model plus frame-order scoreboard monitor.
module tb_tx_fifo_ctrlmod;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned GAPC  = 4;
`ifdef TX_FIFO_CTRL_GAP_EN
    localparam int unsigned GAPW  = GAPC;
`else
    localparam int unsigned GAPW  = 0;
`endif

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          iWrite = 1'b0;
    logic [7:0]    iWData = 8'h00;
    logic          iDone = 1'b0;
    logic          oFull;
    logic          oEmpty;
    logic [AW:0]   oCount;
    logic          oOverflow;
    logic          oCall;
    logic [7:0]    oData;
    logic          oBusy;
    logic          oSent;

    tx_fifo_ctrlmod #(
        .AW(AW),
        .GAP_CYCLES(GAPC)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .iWrite(iWrite),
        .iWData(iWData),
        .oFull(oFull),
        .oEmpty(oEmpty),
        .oCount(oCount),
        .oOverflow(oOverflow),
        .oCall(oCall),
        .oData(oData),
        .iDone(iDone),
        .oBusy(oBusy),
        .oSent(oSent)
    );

    always #5 CLOCK = ~CLOCK;

    int nCmp = 0;
    int nBad = 0;

    // Reference model: FIFO contents, frame in progress, idle wait.
    logic [7:0] mq[$];
    logic [7:0] sbQ[$];
    bit         mBusy = 0;
    int         idleWait = 0;
    int         callAge = 0;
    int         doneDelay = 0;
    bit         mOvf = 0;
    bit         expSent = 0;
    bit         autoDone = 0;
    bit         forceDone = 0;
    bit         spurious = 0;
    bit         randDelay = 0;
    int         fixDelay = 0;
    bit         monEn = 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        chk("count", 32'(oCount), 32'(mq.size()));
        chk("empty", 32'(oEmpty), 32'(mq.size() == 0));
        chk("full", 32'(oFull), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(oOverflow), 32'(mOvf));
        chk("call", 32'(oCall), 32'(mBusy));
        chk("busy", 32'(oBusy), 32'(mBusy || idleWait > 0));
        chk("sent", 32'(oSent), 32'(expSent));
    endtask

    task automatic modelReset();
        mq.delete();
        sbQ.delete();
        mBusy    = 0;
        idleWait = 0;
        callAge  = 0;
        mOvf     = 0;
        expSent  = 0;
    endtask

    task automatic step(input bit w, input logic [7:0] d);
        bit doneE;
        bit popE;
        bit accE;
        @(negedge CLOCK);
        iWrite = w;
        iWData = d;
        iDone  = 1'b0;
        if (forceDone) begin
            iDone = 1'b1;
        end else if (autoDone && mBusy && callAge == doneDelay) begin
            iDone = 1'b1;
        end else if (spurious && !mBusy && $urandom_range(0, 5) == 0) begin
            iDone = 1'b1;
        end
        @(posedge CLOCK);
        doneE = mBusy && iDone;
        popE  = !mBusy && idleWait == 0 && mq.size() != 0;
        accE  = w && mq.size() < DEPTH;
        expSent = doneE;
        if (idleWait > 0) idleWait--;
        if (doneE) begin
            mBusy    = 0;
            idleWait = GAPW;
        end else if (mBusy) begin
            callAge++;
        end
        if (popE) begin
            void'(mq.pop_front());
            mBusy     = 1;
            callAge   = 0;
            doneDelay = randDelay ? $urandom_range(0, 5) : fixDelay;
        end
        if (accE) begin
            mq.push_back(d);
            sbQ.push_back(d);
        end else if (w) begin
            mOvf = 1;
        end
        #1;
        checkAll();
    endtask

    // Monitor: each oCall rise must carry the oldest accepted byte,
    // and oData must hold for the whole frame.
    initial begin : monitor
        logic       prevCall;
        logic [7:0] cur;
        prevCall = 1'b0;
        cur      = 8'h00;
        forever begin
            @(posedge CLOCK);
            #1;
            if (monEn && oCall && !prevCall) begin
                nCmp++;
                if (sbQ.size() == 0) begin
                    nBad++;
                    $display("FAIL frame: got %0h expected none", oData);
                end else begin
                    cur = sbQ.pop_front();
                    nCmp--;
                    chk("frameData", 32'(oData), 32'(cur));
                end
            end else if (monEn && oCall && prevCall) begin
                chk("dataStable", 32'(oData), 32'(cur));
            end
            prevCall = oCall;
        end
    end

    initial begin
        // Reset held for 3 cycles
        RESET = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rstEmpty", 32'(oEmpty), 32'd1);
        chk("rstCount", 32'(oCount), 32'd0);
        chk("rstCall", 32'(oCall), 32'd0);
        chk("rstData", 32'(oData), 32'h00);
        chk("rstOvf", 32'(oOverflow), 32'd0);
        chk("rstBusy", 32'(oBusy), 32'd0);
        chk("rstSent", 32'(oSent), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;

        // Single byte, done 20 cycles after call
        autoDone = 1;
        fixDelay = 19;
        step(1, 8'hA5);
        step(0, 8'h00);
        chk("singleData", 32'(oData), 32'hA5);
        repeat (25) step(0, 8'h00);

        // Ordered burst 00..0F
        fixDelay = 9;
        for (int i = 0; i < 16; i++) step(1, 8'(i));
        repeat (16 * (12 + GAPW) + 10) step(0, 8'h00);

        // Same-edge write and pop with count 3
        autoDone = 0;
        step(1, 8'h31);
        step(1, 8'h32);
        step(1, 8'h33);
        step(1, 8'h34);
        step(0, 8'h00);
        forceDone = 1;
        step(0, 8'h00);
        forceDone = 0;
        repeat (GAPW) step(0, 8'h00);
        step(1, 8'h35);
        chk("simulCount", 32'(oCount), 32'd3);
        chk("simulOvf", 32'(oOverflow), 32'd0);
        autoDone = 1;
        fixDelay = 2;
        repeat (40) step(0, 8'h00);

        // Full and overflow: 18 writes with no iDone
        autoDone = 0;
        for (int i = 0; i < 18; i++) step(1, 8'(8'h40 + i));
        chk("fullFlag", 32'(oFull), 32'd1);
        chk("ovfFlag", 32'(oOverflow), 32'd1);
        forceDone = 1;
        step(0, 8'h00);
        forceDone = 0;
        repeat (GAPW + 1) step(0, 8'h00);
        chk("afterPopData", 32'(oData), 32'h41);
        chk("afterPopFull", 32'(oFull), 32'd0);

        // Randomized traffic with spurious iDone outside frames
        autoDone  = 1;
        randDelay = 1;
        spurious  = 1;
        repeat (300) step($urandom_range(0, 9) < 4, 8'($urandom));
        repeat (300) step($urandom_range(0, 9) < 1, 8'($urandom));

        // Mid-frame asynchronous reset
        for (int i = 0; i < 50 && !mBusy; i++) step(1, 8'($urandom));
        step(1, 8'h77);
        step(1, 8'h78);
        @(negedge CLOCK);
        iWrite = 1'b0;
        iDone  = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        monEn = 0;
        modelReset();
        chk("midRstCall", 32'(oCall), 32'd0);
        chk("midRstCount", 32'(oCount), 32'd0);
        chk("midRstData", 32'(oData), 32'h00);
        chk("midRstBusy", 32'(oBusy), 32'd0);
        chk("midRstOvf", 32'(oOverflow), 32'd0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(posedge CLOCK);
        #2;
        monEn = 1;

        // Post-reset traffic and bounded drain
        repeat (200) step($urandom_range(0, 9) < 3, 8'($urandom));
        for (int i = 0; i < 2000 &&
             (mq.size() != 0 || mBusy || idleWait != 0); i++) begin
            step(0, 8'h00);
        end
        repeat (3) step(0, 8'h00);
        chk("drainModel", 32'(mq.size()), 32'd0);
        chk("drainScoreboard", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
